pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/riscv_pkg.sv | 14 +
 rtl/sat_counter16.sv | 29 ++
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcodes and controller state encoding shared by the pipeline control slice
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALT   = 2'd2,
      ST_RESUME = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit event counter that sticks at all-ones
module sat_counter16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - in-order pipeline enable/flush control with boot, halt and hazard counters
module pipeline_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_rd,
   input  logic [6:0]  ex_op,
   input  logic        ex_branch_taken,
   input  logic        resume,
   output logic        pc_ena,
   output logic        ena_ifid,
   output logic        flush_ifid,
   output logic        ena_idex,
   output logic        halted,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   ctrl_state_e state_q, state_d;
   logic [3:0]  boot_cnt_q, boot_cnt_d;
   logic        load_use;
   logic        stall_inc;
   logic        flush_inc;

   assign load_use = (ex_op == OP_LOAD) && (ex_rd != 5'd0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      pc_ena     = 1'b0;
      ena_ifid   = 1'b0;
      flush_ifid = 1'b0;
      ena_idex   = 1'b0;
      halted     = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      case (state_q)
         ST_BOOT: begin
            flush_ifid = 1'b1;
            if (boot_cnt_q == BOOT_LAST) begin
               state_d    = ST_RUN;
               boot_cnt_d = 4'd0;
            end else begin
               boot_cnt_d = boot_cnt_q + 4'd1;
            end
         end
         ST_RUN: begin
            // A taken branch squashes the dependent instruction, so it wins over load-use.
            if (ex_branch_taken) begin
               pc_ena     = 1'b1;
               ena_ifid   = 1'b1;
               flush_ifid = 1'b1;
               flush_inc  = 1'b1;
            end else if (load_use) begin
               stall_inc  = 1'b1;
            end else begin
               pc_ena     = 1'b1;
               ena_ifid   = 1'b1;
               ena_idex   = 1'b1;
            end
            if ((ex_op == OP_SYSTEM) && !ex_branch_taken) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
            if (resume) begin
               state_d = ST_RESUME;
            end
         end
         ST_RESUME: begin
            pc_ena   = 1'b1;
            ena_ifid = 1'b1;
            ena_idex = 1'b1;
            state_d  = ST_RUN;
         end
         default: state_d = ST_BOOT;
      endcase
      if (rst) begin
         state_d    = ST_BOOT;
         boot_cnt_d = 4'd0;
         pc_ena     = 1'b0;
         ena_ifid   = 1'b0;
         flush_ifid = 1'b1;
         ena_idex   = 1'b0;
         halted     = 1'b0;
         stall_inc  = 1'b0;
         flush_inc  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
      end
   end

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl boot, hazard, halt and counter behaviour
module tb_pipeline_ctrl;

   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] SYS = 7'b1110011;
   localparam logic [6:0] ALU = 7'b0110011;

   // {pc_ena, ena_ifid, flush_ifid, ena_idex, halted}
   localparam logic [4:0] O_BOOT  = 5'b00100;
   localparam logic [4:0] O_RUN   = 5'b11010;
   localparam logic [4:0] O_STALL = 5'b00000;
   localparam logic [4:0] O_FLUSH = 5'b11100;
   localparam logic [4:0] O_HALT  = 5'b00001;

   typedef struct packed {
      logic [4:0]  outs;
      logic [15:0] stall;
      logic [15:0] flush;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
   logic [6:0]  ex_op = '0;
   logic        ex_branch_taken = 1'b0, resume = 1'b0;
   logic        pc_ena, ena_ifid, flush_ifid, ena_idex, halted;
   logic [15:0] stall_cnt, flush_cnt;

   exp_t        sb[$];
   logic [15:0] m_stall = 16'd0;
   logic [15:0] m_flush = 16'd0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.BOOT_CYCLES(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rs1_used     (id_rs1_used),
      .id_rs2_used     (id_rs2_used),
      .ex_rd           (ex_rd),
      .ex_op           (ex_op),
      .ex_branch_taken (ex_branch_taken),
      .resume          (resume),
      .pc_ena          (pc_ena),
      .ena_ifid        (ena_ifid),
      .flush_ifid      (flush_ifid),
      .ena_idex        (ena_idex),
      .halted          (halted),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic [6:0] op, input logic br, input logic res);
      @(posedge clk);
      #1;
      rst = r; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
      ex_rd = rd; ex_op = op; ex_branch_taken = br; resume = res;
   endtask

   // Counter expectations are the values visible during this cycle, before its own increment.
   task automatic step(input string tag, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic [6:0] op,
                       input logic br, input logic res, input logic [4:0] exp_out);
      exp_t e;
      drive(r, rs1, rs2, u1, u2, rd, op, br, res);
      sb.push_back('{outs: exp_out, stall: m_stall, flush: m_flush});
      @(negedge clk);
      e = sb.pop_front();
      check({tag, ":outs"}, {27'd0, pc_ena, ena_ifid, flush_ifid, ena_idex, halted}, {27'd0, e.outs});
      check({tag, ":stall_cnt"}, {16'd0, stall_cnt}, {16'd0, e.stall});
      check({tag, ":flush_cnt"}, {16'd0, flush_cnt}, {16'd0, e.flush});
   endtask

   task automatic nop(input string tag, input logic [4:0] exp_out);
      step(tag, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, ALU, 1'b0, 1'b0, exp_out);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step("reset", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 7'd0, 1'b0, 1'b1, O_BOOT);
      nop("boot0", O_BOOT);
      nop("boot1", O_BOOT);
      nop("run0", O_RUN);
      nop("run1", O_RUN);

      step("lu_rs2", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, LD, 1'b0, 1'b0, O_STALL);
      m_stall++;
      nop("after_lu", O_RUN);
      step("lu_rd0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, LD, 1'b0, 1'b0, O_RUN);
      step("lu_unused", 1'b0, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, LD, 1'b0, 1'b0, O_RUN);
      step("lu_notload", 1'b0, 5'd7, 5'd2, 1'b1, 1'b1, 5'd7, ALU, 1'b0, 1'b0, O_RUN);
      step("lu_rs1", 1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, LD, 1'b0, 1'b0, O_STALL);
      m_stall++;

      step("br_lu", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, LD, 1'b1, 1'b0, O_FLUSH);
      m_flush++;
      step("br_only", 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, ALU, 1'b1, 1'b0, O_FLUSH);
      m_flush++;
      step("resume_run", 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, ALU, 1'b0, 1'b1, O_RUN);
      nop("run2", O_RUN);

      step("sys", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, SYS, 1'b0, 1'b0, O_RUN);
      for (int i = 0; i < 10; i++)
         step("halt", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, LD, 1'b1, 1'b0, O_HALT);
      step("halt_resume", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 7'd0, 1'b0, 1'b1, O_HALT);
      step("resume_cyc", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, LD, 1'b0, 1'b0, O_RUN);
      nop("post_resume", O_RUN);

      step("sys_br", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, SYS, 1'b1, 1'b0, O_FLUSH);
      m_flush++;
      nop("no_halt", O_RUN);

      step("sys2", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, SYS, 1'b0, 1'b0, O_RUN);
      nop("halt2", O_HALT);
      step("rst_in_halt", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 7'd0, 1'b0, 1'b0, O_BOOT);
      m_stall = 16'd0;
      m_flush = 16'd0;
      nop("reboot0", O_BOOT);
      nop("reboot1", O_BOOT);
      nop("rerun", O_RUN);

      for (int i = 0; i < 65540; i++) begin
         drive(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, LD, 1'b0, 1'b0);
         m_stall = (m_stall == 16'hFFFF) ? m_stall : m_stall + 16'd1;
      end
      nop("sat", O_RUN);
      check("sat_value", {16'd0, stall_cnt}, 32'h0000FFFF);
      step("sat_stall", 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, LD, 1'b0, 1'b0, O_STALL);
      nop("sat_hold", O_RUN);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
